// File: rtl/uart_bus_master.sv
// UART command bridge: 'W'/'R' + little-endian address (+ write data) drives one valid/ready bus transfer.
// Optional bus timeout: define UART_BUS_MASTER_TIMEOUT_EN (then TIMEOUT_CYCLES applies).
`timescale 1ns/1ps
module uart_bus_master #(
   parameter int CLK_FREQ       = 1000000,
   parameter int BAUDRATE       = 115200,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        rx,
   output logic        tx,
   output logic        mem_valid,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready
);

   localparam int BIT_DURATION = (CLK_FREQ + BAUDRATE / 2) / BAUDRATE;
   localparam int HALF_BIT     = BIT_DURATION / 2;
   localparam int CW           = $clog2(BIT_DURATION + 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_DURATION - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
   localparam logic [7:0] CMD_W = 8'h57;
   localparam logic [7:0] CMD_R = 8'h52;

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [2:0] {ST_CMD, ST_ADDR, ST_WDATA, ST_BUS, ST_RESP} st_t;

   // ---------------- receiver ----------------
   rx_state_t     rx_state, rx_next;
   logic [2:0]    rx_sync;
   logic          rx_s, rx_fall;
   logic [CW-1:0] rx_cnt;
   logic [2:0]    rx_bit;
   logic [7:0]    rx_byte;
   logic          rx_valid, rx_err;

   assign rx_s    = rx_sync[1];
   assign rx_fall = rx_sync[2] & ~rx_sync[1];

   always_comb begin
      rx_next = rx_state;
      case (rx_state)
         RX_IDLE:  if (rx_fall) rx_next = RX_START;
         RX_START: if (rx_cnt == HALF_LAST) rx_next = rx_s ? RX_IDLE : RX_DATA;
         RX_DATA:  if (rx_cnt == BIT_LAST && rx_bit == 3'd7) rx_next = RX_STOP;
         RX_STOP:  if (rx_cnt == BIT_LAST) rx_next = RX_IDLE;
         default:  rx_next = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rx_state <= RX_IDLE;
         rx_sync  <= '1;
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_byte  <= '0;
         rx_valid <= 1'b0;
         rx_err   <= 1'b0;
      end else begin
         rx_state <= rx_next;
         rx_sync  <= {rx_sync[1:0], rx};
         rx_valid <= 1'b0;
         rx_err   <= 1'b0;
         if (rx_state == RX_IDLE || rx_next != rx_state ||
             (rx_state == RX_DATA && rx_cnt == BIT_LAST))
            rx_cnt <= '0;
         else
            rx_cnt <= rx_cnt + CW'(1);
         if (rx_state == RX_IDLE)
            rx_bit <= '0;
         if (rx_state == RX_DATA && rx_cnt == BIT_LAST) begin
            rx_byte <= {rx_s, rx_byte[7:1]};
            rx_bit  <= rx_bit + 3'd1;
         end
         // A low stop bit is reported separately so the parser can drop the command.
         if (rx_state == RX_STOP && rx_cnt == BIT_LAST) begin
            rx_valid <= rx_s;
            rx_err   <= ~rx_s;
         end
      end
   end

   // ---------------- transmitter ----------------
   logic [9:0]    tx_shift;
   logic [3:0]    tx_bit;
   logic [CW-1:0] tx_cnt;
   logic          tx_busy, tx_ready, tx_start;
   logic [7:0]    tx_byte;

   // Ready on the final stop-bit cycle too, so response bytes go out back-to-back.
   assign tx_ready = !tx_busy || (tx_bit == 4'd9 && tx_cnt == BIT_LAST);
   assign tx       = tx_shift[0];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         tx_shift <= '1;
         tx_bit   <= '0;
         tx_cnt   <= '0;
         tx_busy  <= 1'b0;
      end else if (tx_start) begin
         tx_shift <= {1'b1, tx_byte, 1'b0};
         tx_bit   <= '0;
         tx_cnt   <= '0;
         tx_busy  <= 1'b1;
      end else if (tx_busy) begin
         if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            tx_shift <= {1'b1, tx_shift[9:1]};
            tx_bit   <= tx_bit + 4'd1;
            if (tx_bit == 4'd9) tx_busy <= 1'b0;
         end else begin
            tx_cnt <= tx_cnt + CW'(1);
         end
      end
   end

   // ---------------- parser / bus ----------------
   st_t         state, state_next;
   logic        is_write, bus_err, bus_tmo;
   logic [1:0]  byte_cnt;
   logic [2:0]  resp_idx, resp_len;
   logic [31:0] rdata;

`ifdef UART_BUS_MASTER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tmo_cnt;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)        tmo_cnt <= '0;
      else if (!mem_valid) tmo_cnt <= '0;
      else                tmo_cnt <= tmo_cnt + TW'(1);
   end

   assign bus_tmo = mem_valid && !mem_ready && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
   assign bus_tmo = 1'b0;
`endif

   assign resp_len = (is_write || bus_err) ? 3'd1 : 3'd4;
   assign tx_start = (state == ST_RESP) && (resp_idx != resp_len) && tx_ready;

   always_comb begin
      tx_byte = rdata[{resp_idx[1:0], 3'b000} +: 8];
      if (bus_err)       tx_byte = 8'h45;
      else if (is_write) tx_byte = 8'h4B;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_CMD:
            if (rx_valid && (rx_byte == CMD_W || rx_byte == CMD_R)) state_next = ST_ADDR;
         ST_ADDR:
            if (rx_err) state_next = ST_CMD;
            else if (rx_valid && byte_cnt == 2'd3) state_next = is_write ? ST_WDATA : ST_BUS;
         ST_WDATA:
            if (rx_err) state_next = ST_CMD;
            else if (rx_valid && byte_cnt == 2'd3) state_next = ST_BUS;
         ST_BUS:
            if (mem_valid && (mem_ready || bus_tmo)) state_next = ST_RESP;
         ST_RESP:
            if (resp_idx == resp_len && !tx_busy) state_next = ST_CMD;
         default: state_next = ST_CMD;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= ST_CMD;
      else         state <= state_next;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         mem_valid <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_wstrb <= '0;
         rdata     <= '0;
         is_write  <= 1'b0;
         bus_err   <= 1'b0;
         byte_cnt  <= '0;
         resp_idx  <= '0;
      end else begin
         case (state)
            ST_CMD:
               if (state_next == ST_ADDR) begin
                  is_write <= (rx_byte == CMD_W);
                  bus_err  <= 1'b0;
                  byte_cnt <= '0;
                  resp_idx <= '0;
               end
            ST_ADDR, ST_WDATA:
               if (rx_err) begin
                  byte_cnt <= '0;
               end else if (rx_valid) begin
                  if (state == ST_ADDR) mem_addr[{byte_cnt, 3'b000} +: 8]  <= rx_byte;
                  else                  mem_wdata[{byte_cnt, 3'b000} +: 8] <= rx_byte;
                  byte_cnt <= byte_cnt + 2'd1;
               end
            ST_BUS:
               // First ST_BUS cycle raises the request; the strobe is fixed for its whole life.
               if (!mem_valid) begin
                  mem_valid <= 1'b1;
                  mem_wstrb <= is_write ? 4'hF : 4'h0;
               end else if (mem_ready) begin
                  mem_valid <= 1'b0;
                  if (!is_write) rdata <= mem_rdata;
               end else if (bus_tmo) begin
                  mem_valid <= 1'b0;
                  bus_err   <= 1'b1;
               end
            ST_RESP:
               if (tx_start) resp_idx <= resp_idx + 3'd1;
            default: ;
         endcase
      end
   end

endmodule
